mvm_result_buffer: RTL and testbench

MVM_RESULT_BUFFER -- requirements
Module: mvm_result_buffer

---
 rtl/mvm_pkg.sv | 10 +
 rtl/mvm_rb_bank.sv | 26 ++
 rtl/mvm_result_buffer.sv | 130 +++++++++++++
 tb/tb_mvm_result_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared sizing, FSM state encodings and bank index type for the MVM result buffer.
package mvm_pkg;
    localparam int M  = 4;
    localparam int RW = 12;

    typedef enum logic {C_IDLE, C_CAPT} cap_state_t;
    typedef enum logic {D_IDLE, D_SEND} drn_state_t;

    typedef logic bank_t;
endpackage

// File: rtl/mvm_rb_bank.sv
// Ping-pong storage: two banks of M result words, one write port, one combinational read port.
module mvm_rb_bank
    import mvm_pkg::bank_t;
#(
    parameter int M  = mvm_pkg::M,
    parameter int RW = mvm_pkg::RW,
    parameter int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  bank_t                i_wsel,
    input  logic [IW-1:0]        i_waddr,
    input  logic signed [RW-1:0] i_wdata,
    input  bank_t                i_rsel,
    input  logic [IW-1:0]        i_raddr,
    output logic signed [RW-1:0] o_rdata
);
    // Contents are don't-care after reset; the full flags gate every read.
    logic signed [RW-1:0] r_mem [2][M];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wsel][i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_rsel][i_raddr];
endmodule

// File: rtl/mvm_result_buffer.sv
// Double-buffered capture of MVM result vectors with a valid/ready drain port.
// Optional MVM_RESULT_RELU_EN clamps negative words to zero before storage.
module mvm_result_buffer
    import mvm_pkg::cap_state_t, mvm_pkg::C_IDLE, mvm_pkg::C_CAPT,
           mvm_pkg::drn_state_t, mvm_pkg::D_IDLE, mvm_pkg::D_SEND, mvm_pkg::bank_t;
#(
    parameter int M  = mvm_pkg::M,
    parameter int RW = mvm_pkg::RW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 done,
    input  logic signed [RW-1:0] data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [RW-1:0] out_data,
    output logic                 out_last,
    output logic                 overflow
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    cap_state_t    r_cstate;
    logic [IW-1:0] r_cidx;
    bank_t         r_fill;
    drn_state_t    r_dstate;
    logic [IW-1:0] r_didx;
    bank_t         r_drain;
    logic [1:0]    r_full;
    logic          r_overflow;

    logic                 w_cap_we, w_cap_end, w_xfer, w_free, w_fill_busy, w_other_full;
    logic [1:0]           w_set, w_clr;
    logic signed [RW-1:0] w_wdata, w_rdata;

`ifdef MVM_RESULT_RELU_EN
    assign w_wdata = data_in[RW-1] ? '0 : data_in;
`else
    assign w_wdata = data_in;
`endif

    assign w_cap_we  = (r_cstate == C_CAPT);
    assign w_cap_end = w_cap_we && (r_cidx == LAST);
    assign w_xfer    = (r_dstate == D_SEND) && out_ready;
    assign w_free    = w_xfer && (r_didx == LAST);
    // A bank whose last word leaves on this edge may be refilled starting next edge.
    assign w_fill_busy  = r_full[r_fill] && !(w_free && (r_drain == r_fill));
    assign w_other_full = r_full[~r_drain] || (w_cap_end && (r_fill != r_drain));

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_cap_end) w_set[r_fill]  = 1'b1;
        if (w_free)    w_clr[r_drain] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cstate   <= C_IDLE;
            r_cidx     <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_cstate)
                C_IDLE: if (done) begin
                    if (w_fill_busy) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_cstate <= C_CAPT;
                        r_cidx   <= '0;
                    end
                end
                C_CAPT: begin
                    r_cidx <= r_cidx + 1'b1;
                    if (r_cidx == LAST) begin
                        r_cstate <= C_IDLE;
                        r_fill   <= ~r_fill;
                    end
                end
                default: r_cstate <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_full <= '0;
        else        r_full <= (r_full | w_set) & ~w_clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dstate <= D_IDLE;
            r_didx   <= '0;
            r_drain  <= '0;
        end else begin
            case (r_dstate)
                D_IDLE: if (r_full[r_drain]) begin
                    r_dstate <= D_SEND;
                    r_didx   <= '0;
                end
                D_SEND: if (out_ready) begin
                    if (r_didx == LAST) begin
                        r_drain <= ~r_drain;
                        r_didx  <= '0;
                        if (!w_other_full) r_dstate <= D_IDLE;
                    end else begin
                        r_didx <= r_didx + 1'b1;
                    end
                end
                default: r_dstate <= D_IDLE;
            endcase
        end
    end

    mvm_rb_bank #(.M(M), .RW(RW), .IW(IW)) u_bank (
        .clk     (clk),
        .i_we    (w_cap_we),
        .i_wsel  (r_fill),
        .i_waddr (r_cidx),
        .i_wdata (w_wdata),
        .i_rsel  (r_drain),
        .i_raddr (r_didx),
        .o_rdata (w_rdata)
    );

    assign out_valid = (r_dstate == D_SEND);
    assign out_last  = out_valid && (r_didx == LAST);
    assign out_data  = out_valid ? w_rdata : '0;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_mvm_result_buffer.sv
// Self-checking bench for mvm_result_buffer (M=4, RW=12): table vectors plus corner sequences.
module tb_mvm_result_buffer;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               done = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [11:0] data_in = '0;
    logic               out_valid, out_last, overflow;
    logic signed [11:0] out_data;

    always #5 clk = ~clk;

    mvm_result_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    typedef struct { int din[4]; int exp[4]; } vec_t;
    typedef struct { logic [11:0] data; logic last; } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    vec_t        tbl[3];
    logic        stalled = 1'b0;
    logic [11:0] held_d = '0;
    logic        held_l = 1'b0;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Scoreboard and stall-hold checker, evaluated once per cycle at the falling edge.
    task automatic mon();
        exp_t e;
        if (stalled) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'($unsigned(out_data)), int'(held_d));
            chk("hold_last", int'(out_last), int'(held_l));
        end
        stalled = out_valid && !out_ready;
        held_d  = out_data;
        held_l  = out_last;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", int'(out_valid), 0);
            end else begin
                e = q.pop_front();
                chk("data", int'($unsigned(out_data)), int'(e.data));
                chk("last", int'(out_last), int'(e.last));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input vec_t v, input bit keep);
        exp_t e;
        if (keep) begin
            for (int i = 0; i < 4; i++) begin
                e.data = 12'(v.exp[i]);
                e.last = (i == 3);
                q.push_back(e);
            end
        end
        done = 1'b1;
        cyc();
        done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = 12'(v.din[i]);
            cyc();
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_left", q.size(), 0);
        repeat (3) cyc();
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t r;
        r.din = '{a, b, c, d};
        r.exp = '{a, b, c, d};
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].din = '{5, -3, 0, 2047};
        tbl[1].din = '{-1, -2048, 100, -7};
        tbl[2].din = '{1, -1, 2046, -2047};
`ifdef MVM_RESULT_RELU_EN
        tbl[0].exp = '{5, 0, 0, 2047};
        tbl[1].exp = '{0, 0, 100, 0};
        tbl[2].exp = '{1, 0, 2046, 0};
`else
        tbl[0].exp = '{5, -3, 0, 2047};
        tbl[1].exp = '{-1, -2048, 100, -7};
        tbl[2].exp = '{1, -1, 2046, -2047};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_data", int'($unsigned(out_data)), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 1'b1;
        out_ready = 1'b1;
        cyc();

        // Table vectors, out_ready held high; first one also checks EM->valid latency
        for (int t = 0; t < 3; t++) begin
            send_vec(tbl[t], 1'b1);
            if (t == 0) begin
                chk("lat_at_em", int'(out_valid), 0);
                cyc();
                chk("lat_em_plus1", int'(out_valid), 1);
            end
            drain(20);
        end
        chk("ovf_idle", int'(overflow), 0);

        // Ready toggling every cycle during a drain
        out_ready = 1'b0;
        send_vec(mk(11, 12, 13, 14), 1'b1);
        for (int n = 0; n < 40 && q.size() != 0; n++) begin
            out_ready = ~out_ready;
            cyc();
        end
        chk("toggle_left", q.size(), 0);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Three vectors with a blocked sink: third is dropped, overflow sticks
        out_ready = 1'b0;
        send_vec(mk(1, 2, 3, 4), 1'b1);
        send_vec(mk(5, 6, 7, 8), 1'b1);
        chk("ovf_before_drop", int'(overflow), 0);
        send_vec(mk(9, 10, 11, 12), 1'b0);
        chk("ovf_after_drop", int'(overflow), 1);
        out_ready = 1'b1;
        drain(40);
        chk("ovf_sticky", int'(overflow), 1);
        reset = 1'b0;
        #1;
        chk("ovf_reset", int'(overflow), 0);
        cyc();
        reset = 1'b1;
        cyc();

        // Reset in the middle of a capture discards the partial vector
        out_ready = 1'b1;
        done = 1'b1;
        cyc();
        done = 1'b0;
        data_in = 12'sd1;
        cyc();
        data_in = 12'sd2;
        cyc();
        reset = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        cyc();
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cyc();
            chk("midrst_quiet", int'(out_valid), 0);
        end
        chk("midrst_ovf", int'(overflow), 0);
        send_vec(mk(7, 7, 7, 7), 1'b1);
        drain(20);

        // Both banks full; third done lands on the edge that frees bank 0,
        // and its last word lands on the edge that frees bank 1
        out_ready = 1'b0;
        send_vec(mk(21, 22, 23, 24), 1'b1);
        send_vec(mk(31, 32, 33, 34), 1'b1);
        out_ready = 1'b1;
        repeat (3) cyc();
        send_vec(mk(41, 42, 43, 44), 1'b1);
        chk("coinc_ovf", int'(overflow), 0);
        drain(40);
        chk("coinc_ovf_end", int'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
